spi_byte_rx: RTL and testbench
==============================

# spi_byte_rx

Receive-side companion to the SPI byte transmitter: deserializes a clock/enable/data stream, as produced by the transmitter's clk_out/en_out/out pins, back into 8-bit bytes in the local clk domain. All three serial inputs are asynchronous to clk; they are synchronized and spi_clk rising edges are detected by oversampling. Completed bytes are held in one output register with a valid/ready handshake. Overrun and framing errors are flagged.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_clk/spi_en/spi_data (legal 2..4)
- MSB_FIRST, 1, 1 = first received bit lands in data_out[7]; 0 = in data_out[0]

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- spi_clk  in  1  serial clock from transmitter, async; data sampled on its rising edge
- spi_en  in  1  frame enable, active-high, async
- spi_data  in  1  serial data, async
- data_out  out  8  received byte
- out_valid  out  1  data_out holds an unread byte
- out_ready  in  1  consumer accepts data_out when high with out_valid
- busy  out  1  synchronized spi_en
- frame_err  out  1  one-cycle pulse: frame ended mid-byte
- overrun  out  1  sticky: byte dropped because holding register was full
- clr_err  in  1  synchronous clear of overrun

## Operation
- Sync: spi_clk, spi_en, spi_data each pass through SYNC_STAGES flops. One extra flop on synced spi_clk gives sclk_prev. Rising edge event rise = sclk_s & ~sclk_prev.
- busy = synced spi_en.
- States: IDLE (busy low), SHIFT (busy high, bit_cnt 0..7).
- IDLE: bit_cnt held at 0, shift register held, rise events ignored. busy rising enters SHIFT.
- SHIFT, rise: shift synced spi_data into shift register (left shift if MSB_FIRST, else right shift) and increment bit_cnt (3-bit, wraps 7->0).
- On rise with bit_cnt==7: byte complete. bit_cnt wraps to 0 and stays in SHIFT, so back-to-back bytes within one enable frame need no gap.
- Byte complete, load rule: if out_valid==0, or out_ready==1 in the same cycle, load data_out and set out_valid. Otherwise drop the new byte, set overrun, and keep data_out unchanged.
- out_valid clears on the cycle after out_valid & out_ready, unless a new byte loads in that same cycle (then out_valid stays 1).
- busy falls while in SHIFT:
  - bit_cnt != 0: pulse frame_err for 1 cycle and discard the partial byte.
  - bit_cnt == 0: clean end, no pulse.
  - Either way, go to IDLE with bit_cnt = 0.
- Rise coincident with busy falling: ignored; the enable drop takes priority.
- clr_err clears overrun. If clr_err and a new overrun occur in the same cycle, overrun is set (set wins).

## Timing
- Reset (rst low, async): data_out=8'h00, out_valid=0, busy=0, frame_err=0, overrun=0, bit_cnt=0, shift register=0, all sync flops=0, state IDLE.
- Reset release mid-frame: the block waits in IDLE for busy to rise. A frame already in progress is not captured until spi_en deasserts and reasserts.
- Latency: with SYNC_STAGES=2, out_valid rises on the 3rd clk rising edge after the spi_clk edge carrying the 8th bit. In general the latency is SYNC_STAGES+1 edges.
- Input constraints: spi_clk high time and low time are each ≥ SYNC_STAGES+1 clk periods. spi_data is stable from one clk period before each spi_clk rising edge to one period after it. spi_en rises ≥ SYNC_STAGES+1 clk periods before the first spi_clk rising edge.
- frame_err pulse appears SYNC_STAGES+1 edges after the raw spi_en falling edge.
- Throughput: one byte per 8 spi_clk periods. No bubble cycles between bytes.

## Test plan
- Reset: drive rst low mid-shift with out_valid=1 -> all outputs 0 immediately (asynchronously); the next frame after spi_en re-rises is received correctly.
- Single byte: MSB_FIRST=1, send 8'hA5 with spi_clk period 8 clk, out_ready=1 -> data_out=8'hA5, out_valid high exactly 1 cycle, 3 edges after the 8th spi_clk rise. Repeat with MSB_FIRST=0 and bit order 1,0,1,0,0,1,0,1 -> 8'hA5.
- Back-to-back: in one frame, send 8'hFF, 8'h00, 8'h01, 8'h02 (incrementing pattern) with out_ready=1 -> four valid pulses, correct values in order, no frame_err.
- Overrun: out_ready=0, send 8'h11 then 8'h22 -> data_out stays 8'h11, overrun=1. Pulse clr_err -> overrun=0. Raise out_ready -> out_valid drops the next cycle.
- Simultaneous accept/load: hold out_ready=1 across a completion while out_valid=1 -> new byte loaded, out_valid stays 1, overrun remains 0.
- Framing: drop spi_en after 5 bits -> one frame_err pulse, no out_valid. The next full byte 8'h3C is received correctly.

Source files
------------

// File: rtl/spi_byte_rx.sv
// SPI byte receiver: synchronizes an external clock/enable/data stream and
// deserializes it into bytes held behind a valid/ready output register.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_en,
    input  logic       spi_data,
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clr_err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] FILL_LEN = 3'(SYNC_STAGES);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sclk_prev;
    logic                   sclk_s;
    logic                   en_s;
    logic                   data_s;
    logic                   rise;
    logic [2:0]             fill_cnt;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_next;
    logic [7:0]             shift_reg;
    logic [7:0]             shift_next;
    logic [7:0]             shifted;
    logic                   byte_done;
    logic                   frame_err_next;
    logic                   load;
    logic                   drop;

    // NOTE: every flop below uses <= so all registers update from the same
    // pre-edge values; a blocking = here would let later stages see new data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            en_sync   <= '0;
            data_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            en_sync   <= {en_sync[SYNC_STAGES-2:0], spi_en};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign en_s   = en_sync[SYNC_STAGES-1];
    assign data_s = data_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;
    assign busy   = en_s;

    // The synchronized enable is only trustworthy once the chain has filled
    // after reset; a frame already running at that point must end before we
    // accept a new one, otherwise we would lock onto it mid-byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt <= 3'd0;
            armed    <= 1'b0;
        end else if (fill_cnt != FILL_LEN) begin
            fill_cnt <= fill_cnt + 3'd1;
        end else if (!en_s) begin
            armed <= 1'b1;
        end
    end

    always_comb begin
        if (MSB_FIRST) shifted = {shift_reg[6:0], data_s};
        else           shifted = {data_s, shift_reg[7:1]};
    end

    // NOTE: each output of this block is given a default before the case so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift_reg;
        byte_done      = 1'b0;
        frame_err_next = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_next = 3'd0;
                if (en_s && armed) state_next = SHIFT;
            end
            SHIFT: begin
                if (!en_s) begin
                    // Enable drop outranks a coincident clock rise.
                    state_next     = IDLE;
                    bit_cnt_next   = 3'd0;
                    frame_err_next = (bit_cnt != 3'd0);
                end else if (rise) begin
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt + 3'd1;
                    byte_done    = (bit_cnt == 3'd7);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            frame_err <= frame_err_next;
        end
    end

    // A completed byte loads if the holder is empty or being emptied now.
    assign load = byte_done & (~out_valid | out_ready);
    assign drop = byte_done & ~load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= 8'h00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) data_out <= shifted;

            if (load)           out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            if (drop)         overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Bench for spi_byte_rx: drives one serial stream into an MSB-first and an
// LSB-first receiver and compares both against a byte-level model.
module tb_spi_byte_rx;

    logic       clk;
    logic       rst;
    logic       spi_clk;
    logic       spi_en;
    logic       spi_data;
    logic       out_ready;
    logic       clr_err;
    logic [7:0] do_m;
    logic [7:0] do_l;
    logic       ov_m;
    logic       ov_l;
    logic       busy_m;
    logic       busy_l;
    logic       fe_m;
    logic       fe_l;
    logic       orun_m;
    logic       orun_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int first_valid_cyc = 0;
    int vcnt_m = 0;
    int vcnt_l = 0;
    int fe_cnt_m = 0;
    int fe_cnt_l = 0;
    logic prev_v = 1'b0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    logic [7:0] got_m[$];
    logic [7:0] got_l[$];
    int         acc_cyc[$];

    spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en),
        .spi_data(spi_data), .data_out(do_m), .out_valid(ov_m),
        .out_ready(out_ready), .busy(busy_m), .frame_err(fe_m),
        .overrun(orun_m), .clr_err(clr_err)
    );

    spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_en(spi_en),
        .spi_data(spi_data), .data_out(do_l), .out_valid(ov_l),
        .out_ready(out_ready), .busy(busy_l), .frame_err(fe_l),
        .overrun(orun_l), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Observes handshakes mid-cycle, well clear of the edge where inputs move.
    always @(negedge clk) begin
        if (ov_m && out_ready) begin
            got_m.push_back(do_m);
            acc_cyc.push_back(cyc);
        end
        if (ov_l && out_ready) got_l.push_back(do_l);
        if (ov_m) vcnt_m++;
        if (ov_l) vcnt_l++;
        if (ov_m && !prev_v) first_valid_cyc = cyc;
        prev_v = ov_m;
        if (fe_m) fe_cnt_m++;
        if (fe_l) fe_cnt_l++;
    end

    function automatic logic [7:0] rev8(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) r = r + (((int'(v) >> i) & 1) << (7 - i));
        return 8'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit raise_ready);
        spi_data = b;
        tick();
        spi_clk  = 1'b1;
        rise_cyc = cyc;
        tick();
        tick();
        if (raise_ready) out_ready = 1'b1;
        tick();
        tick();
        spi_clk = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int extra);
        logic [7:0] b;
        spi_en = 1'b1;
        repeat (4) tick();
        foreach (tx_q[k]) begin
            b = tx_q[k];
            for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        end
        for (int j = 0; j < extra; j++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (2) tick();
        spi_en = 1'b0;
        repeat (6) tick();
    endtask

    task automatic push_exp();
        foreach (tx_q[k]) begin
            exp_m.push_back(tx_q[k]);
            exp_l.push_back(rev8(tx_q[k]));
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count_msb"}, got_m.size(), exp_m.size());
        check({tag, "_count_lsb"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_m.size(); i++)
            if (i < got_m.size()) check({tag, "_byte_msb"}, got_m[i], exp_m[i]);
        for (int i = 0; i < exp_l.size(); i++)
            if (i < got_l.size()) check({tag, "_byte_lsb"}, got_l[i], exp_l[i]);
        got_m.delete();
        got_l.delete();
        exp_m.delete();
        exp_l.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int v0_m;
        int v0_l;
        int fe0_m;
        int fe0_l;
        int nbytes;
        int extra;
        logic [7:0] b;

        rst       = 1'b0;
        spi_clk   = 1'b0;
        spi_en    = 1'b0;
        spi_data  = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        repeat (3) tick();
        check("rst_data", do_m, 8'h00);
        check("rst_valid", ov_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_ferr", fe_m, 1'b0);
        check("rst_overrun", orun_m, 1'b0);
        rst = 1'b1;
        repeat (5) tick();

        // Single byte, both bit orders, with latency and pulse width.
        v0_m = vcnt_m;
        v0_l = vcnt_l;
        tx_q = '{8'hA5};
        push_exp();
        send_frame(0);
        check("single_valid_cycles_msb", vcnt_m - v0_m, 1);
        check("single_valid_cycles_lsb", vcnt_l - v0_l, 1);
        check("single_latency", first_valid_cyc - rise_cyc, 3);
        compare_rx("single");

        // Back-to-back bytes inside one enable frame.
        fe0_m = fe_cnt_m;
        tx_q = '{8'hFF, 8'h00, 8'h01, 8'h02};
        push_exp();
        send_frame(0);
        check("b2b_no_ferr", fe_cnt_m - fe0_m, 0);
        compare_rx("b2b");

        // Random frames, some ending with a partial byte.
        for (int it = 0; it < 4; it++) begin
            fe0_m  = fe_cnt_m;
            fe0_l  = fe_cnt_l;
            nbytes = $urandom_range(1, 3);
            extra  = $urandom_range(0, 7);
            tx_q.delete();
            for (int k = 0; k < nbytes; k++) tx_q.push_back(8'($urandom));
            push_exp();
            send_frame(extra);
            check("rand_ferr_msb", fe_cnt_m - fe0_m, (extra != 0) ? 1 : 0);
            check("rand_ferr_lsb", fe_cnt_l - fe0_l, (extra != 0) ? 1 : 0);
            compare_rx("rand");
        end

        // Overrun: second byte dropped while the holder is full.
        out_ready = 1'b0;
        tx_q = '{8'h11, 8'h22};
        send_frame(0);
        check("ovr_data_msb", do_m, 8'h11);
        check("ovr_data_lsb", do_l, rev8(8'h11));
        check("ovr_valid", ov_m, 1'b1);
        check("ovr_flag_msb", orun_m, 1'b1);
        check("ovr_flag_lsb", orun_l, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_cleared", orun_m, 1'b0);
        out_ready = 1'b1;
        tick();
        check("ovr_valid_drop", ov_m, 1'b0);
        tx_q = '{8'h11};
        push_exp();
        compare_rx("ovr");

        // Accept of the held byte in the same cycle a new byte completes.
        out_ready = 1'b0;
        tx_q = '{8'h47};
        push_exp();
        send_frame(0);
        check("acc_held_valid", ov_m, 1'b1);
        spi_en = 1'b1;
        repeat (4) tick();
        b = 8'hB8;
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == 0);
        repeat (2) tick();
        spi_en = 1'b0;
        repeat (6) tick();
        tx_q = '{8'hB8};
        push_exp();
        check("acc_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("acc_back_to_back", acc_cyc[1] - acc_cyc[0], 1);
        check("acc_no_overrun_msb", orun_m, 1'b0);
        check("acc_no_overrun_lsb", orun_l, 1'b0);
        compare_rx("acc");

        // Framing error after five bits, then a clean byte.
        fe0_m = fe_cnt_m;
        fe0_l = fe_cnt_l;
        v0_m  = vcnt_m;
        tx_q.delete();
        send_frame(5);
        check("frm_pulse_msb", fe_cnt_m - fe0_m, 1);
        check("frm_pulse_lsb", fe_cnt_l - fe0_l, 1);
        check("frm_no_valid", vcnt_m - v0_m, 0);
        tx_q = '{8'h3C};
        push_exp();
        send_frame(0);
        compare_rx("frm");

        // Asynchronous reset mid-shift with a byte held, released mid-frame.
        out_ready = 1'b0;
        tx_q = '{8'h5A};
        send_frame(0);
        spi_en = 1'b1;
        repeat (4) tick();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("pre_rst_valid", ov_m, 1'b1);
        check("pre_rst_busy", busy_m, 1'b1);
        rst = 1'b0;
        #1;
        check("async_rst_data", do_m, 8'h00);
        check("async_rst_valid", ov_m, 1'b0);
        check("async_rst_busy", busy_m, 1'b0);
        check("async_rst_valid_lsb", ov_l, 1'b0);
        repeat (2) tick();
        rst = 1'b1;
        fe0_m = fe_cnt_m;
        b = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        repeat (2) tick();
        spi_en = 1'b0;
        repeat (6) tick();
        check("stale_frame_ignored", ov_m, 1'b0);
        check("stale_frame_no_ferr", fe_cnt_m - fe0_m, 0);
        out_ready = 1'b1;
        tx_q = '{8'h96};
        push_exp();
        send_frame(0);
        compare_rx("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
